pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Top-level game sequencer for the pong design. It tracks the game phase (new game, play, new ball, game over), the remaining ball count and the two-digit BCD score. From these it drives the text overlay's enable mask, the ball/score digit inputs, and a freeze signal for the graphics datapath. It sits between the button/graphics collision logic and the text and graphics renderers, and runs on the pixel clock domain.

## Interface
- BALLS, 3: balls issued per game; loaded into `ball` at game start; range 1..3.
- TIMEOUT, 120: refresh ticks spent in NEWBALL/OVER before advancing; range 1..127.
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset; all state returns to reset values immediately on assertion.
- refr_tick  in  1  one-cycle pulse per frame (start of vertical blank).
- btn  in  2  player buttons, level, already synchronized.
- hit  in  1  one-cycle pulse: ball struck paddle.
- miss  in  1  one-cycle pulse: ball passed paddle.
- graph_still  out  1  1 = graphics datapath frozen/ball parked.
- ball  out  2  balls remaining (not counting ball in play).
- dig0  out  4  score units digit, BCD.
- dig1  out  4  score tens digit, BCD.
- text_en  out  4  overlay enables {score, logo, rule, over}, bit 3 = score.

## Operation
- Button edge: `btn_q` register; `press = |(btn & ~btn_q)`. Holding a button never re-triggers.
- NEWGAME:
  - graph_still=1, text_en=4'b1110.
  - On press: `ball <= ball-1`, go to PLAY.
- PLAY:
  - graph_still=0, text_en=4'b1000.
  - hit → score +1 (BCD).
  - miss with ball==0 → OVER; miss with ball!=0 → `ball <= ball-1`, go to NEWBALL.
  - Both miss transitions load the timer.
- NEWBALL:
  - graph_still=1, text_en=4'b1000.
  - Go to PLAY when timer expired AND press. A press before expiry is ignored (not latched).
- OVER:
  - graph_still=1, text_en=4'b1001.
  - On timer expiry → NEWGAME. Entering NEWGAME clears dig0/dig1 to 0 and loads `ball=BALLS`.
- Score counter:
  - dig0 0..9; at 9 it wraps to 0 and carries into dig1.
  - 99 wraps to 00; no saturation.
  - hit is ignored outside PLAY.
- Timer:
  - 7-bit down-counter, loaded with TIMEOUT on entry to NEWBALL/OVER.
  - Decrements on refr_tick while nonzero; expired == (count==0).
  - A load in the same cycle as refr_tick: load wins.
- Simultaneous hit and miss in PLAY: both take effect; score increments and the miss transition occurs.
- ball never underflows: decrement happens only when ball!=0, by construction of the transitions.

## Timing
- All state, counters and `btn_q` are flops.
- graph_still and text_en are Moore decodes of the state register; they change the cycle after the transition edge.
- Latency: hit at cycle N → dig0/dig1 updated at N+1. miss at N → state, ball and outputs valid at N+1.
- Timer expiry: exactly TIMEOUT refr_ticks after entry. The transition fires in the cycle following the tick that reaches 0 (OVER), or on the first press cycle at or after that point (NEWBALL).
- Reset values:
  - state=NEWGAME, ball=BALLS, dig0=dig1=0, timer=0, btn_q=0.
  - graph_still=1, text_en=4'b1110.
- Reset asserted mid-game: same values, asynchronously. Release is synchronous to clk through the standard reset path; the first press edge after release is honoured.

## Structure
- Shared package `pong_pkg`: state enum (NEWGAME, PLAY, NEWBALL, OVER), text_en bit index constants (TXT_SCORE=3, TXT_LOGO=2, TXT_RULE=1, TXT_OVER=0), BCD digit width.
- Sub-module `bcd2_counter`: ports clk, reset, clr, inc; outputs dig0, dig1. Two-digit BCD counter with wrap; clr has priority over inc.
- FSM, timer and edge detector stay in pong_game_ctrl.

## Test plan
- Reset, then release; hold btn=2'b01 for 10 cycles.
  - Before release: state NEWGAME, ball=3, text_en=1110, graph_still=1.
  - Exactly one transition to PLAY, ball=2, text_en=1000, graph_still=0.
- In PLAY, 12 hit pulses → dig1=1, dig0=2. From 99, one hit → 00.
- In PLAY with ball=2: miss → NEWBALL, ball=1. Press before 120 ticks → stays NEWBALL. Press after tick 120 → PLAY.
- In PLAY with ball=0: miss → OVER, text_en=1001, score held. After 120 refr_ticks → NEWGAME, dig=00, ball=3.
- Same-cycle hit+miss in PLAY with ball=1 and score 09 → score 10, NEWBALL, ball=0.
- Assert reset while in OVER with timer mid-count → outputs return to reset values in the same cycle, asynchronously, without a clock edge.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared types and constants for the pong game controller:
//               game phase encoding, text overlay enable bit positions and
//               the BCD digit width.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    // Game phase
    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    // Bit positions inside the text overlay enable mask
    localparam int TXT_SCORE = 3;
    localparam int TXT_LOGO  = 2;
    localparam int TXT_RULE  = 1;
    localparam int TXT_OVER  = 0;
    localparam int TXT_W     = 4;

    // Width of one BCD score digit
    localparam int DIG_W = 4;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/pong_game_ctrl_bcd2.sv
`default_nettype none
// ============================================================================
// Module      : bcd2_counter
// Description : Two-digit BCD counter, 00..99 with wrap back to 00.
//               clr has priority over inc.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd2_counter
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [DIG_W-1:0] dig0,
    output logic [DIG_W-1:0] dig1
);

    logic [DIG_W-1:0] dig0_q, dig0_d;
    logic [DIG_W-1:0] dig1_q, dig1_d;

    // Next-digit computation: units wrap at 9 and carry into tens, tens wrap at 9
    always_comb begin
        dig0_d = dig0_q;
        dig1_d = dig1_q;
        if (clr) begin
            dig0_d = '0;
            dig1_d = '0;
        end else if (inc) begin
            if (dig0_q == 4'd9) begin
                dig0_d = '0;
                dig1_d = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
            end else begin
                dig0_d = dig0_q + 4'd1;
            end
        end
    end

    // Digit registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dig0_q <= '0;
            dig1_q <= '0;
        end else begin
            dig0_q <= dig0_d;
            dig1_q <= dig1_d;
        end
    end

    assign dig0 = dig0_q;
    assign dig1 = dig1_q;

endmodule : bcd2_counter
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Game sequencer for pong. Tracks the game phase, balls left,
//               BCD score and the NEWBALL/OVER wait timer; drives the text
//               overlay enables and the graphics freeze signal.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALLS   = 3,
    parameter int TIMEOUT = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refr_tick,
    input  logic [1:0]       btn,
    input  logic             hit,
    input  logic             miss,
    output logic             graph_still,
    output logic [1:0]       ball,
    output logic [DIG_W-1:0] dig0,
    output logic [DIG_W-1:0] dig1,
    output logic [TXT_W-1:0] text_en
);

    localparam logic [1:0] c_ball_init = 2'(BALLS);
    localparam logic [6:0] c_timeout   = 7'(TIMEOUT);

    state_t     state_q, state_d;
    logic [1:0] ball_q, ball_d;
    logic [6:0] timer_q, timer_d;
    logic [1:0] btn_q, btn_d;

    logic w_press;
    logic w_timer_load;
    logic w_timer_done;
    logic w_score_clr;
    logic w_score_inc;

    // Rising edge on any button; a held button does not re-trigger
    assign w_press      = |(btn & ~btn_q);
    assign w_timer_done = (timer_q == 7'd0);
    assign btn_d        = btn;

    // Phase transitions, ball accounting and score control
    always_comb begin
        state_d      = state_q;
        ball_d       = ball_q;
        w_timer_load = 1'b0;
        w_score_clr  = 1'b0;
        w_score_inc  = 1'b0;
        case (state_q)
            ST_NEWGAME: begin
                if (w_press) begin
                    ball_d  = ball_q - 2'd1;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                w_score_inc = hit;
                if (miss) begin
                    w_timer_load = 1'b1;
                    if (ball_q == 2'd0) begin
                        state_d = ST_OVER;
                    end else begin
                        ball_d  = ball_q - 2'd1;
                        state_d = ST_NEWBALL;
                    end
                end
            end
            ST_NEWBALL: begin
                // Presses during the wait are dropped, not remembered
                if (w_timer_done && w_press) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (w_timer_done) begin
                    state_d     = ST_NEWGAME;
                    ball_d      = c_ball_init;
                    w_score_clr = 1'b1;
                end
            end
            default: state_d = ST_NEWGAME;
        endcase
    end

    // Wait timer: load beats a coincident refresh tick; stops at zero
    always_comb begin
        timer_d = timer_q;
        if (w_timer_load) begin
            timer_d = c_timeout;
        end else if (refr_tick && !w_timer_done) begin
            timer_d = timer_q - 7'd1;
        end
    end

    // Controller state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_NEWGAME;
            ball_q  <= c_ball_init;
            timer_q <= '0;
            btn_q   <= '0;
        end else begin
            state_q <= state_d;
            ball_q  <= ball_d;
            timer_q <= timer_d;
            btn_q   <= btn_d;
        end
    end

    // Moore decode of the overlay mask from the current phase
    always_comb begin
        text_en = '0;
        case (state_q)
            ST_NEWGAME: begin
                text_en[TXT_SCORE] = 1'b1;
                text_en[TXT_LOGO]  = 1'b1;
                text_en[TXT_RULE]  = 1'b1;
            end
            ST_PLAY, ST_NEWBALL: begin
                text_en[TXT_SCORE] = 1'b1;
            end
            ST_OVER: begin
                text_en[TXT_SCORE] = 1'b1;
                text_en[TXT_OVER]  = 1'b1;
            end
            default: text_en = '0;
        endcase
    end

    assign graph_still = (state_q != ST_PLAY);
    assign ball        = ball_q;

    bcd2_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (w_score_clr),
        .inc   (w_score_inc),
        .dig0  (dig0),
        .dig1  (dig1)
    );

endmodule : pong_game_ctrl
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_ctrl
// Description : Self-checking bench for pong_game_ctrl. A behavioural game
//               model predicts every cycle's outputs into a scoreboard queue;
//               each entry is popped and compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       refr_tick = 1'b0;
    logic [1:0] btn       = 2'b00;
    logic       hit       = 1'b0;
    logic       miss      = 1'b0;
    logic       graph_still;
    logic [1:0] ball;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] text_en;

    always #5 clk = ~clk;

    pong_game_ctrl #(.BALLS(3), .TIMEOUT(120)) dut (
        .clk         (clk),
        .reset       (reset),
        .refr_tick   (refr_tick),
        .btn         (btn),
        .hit         (hit),
        .miss        (miss),
        .graph_still (graph_still),
        .ball        (ball),
        .dig0        (dig0),
        .dig1        (dig1),
        .text_en     (text_en)
    );

    typedef struct packed {
        logic       gs;
        logic [3:0] te;
        logic [1:0] ball;
        logic [3:0] d1;
        logic [3:0] d0;
    } snap_t;

    snap_t sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    // Game model: 0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER
    int         m_st;
    int         m_ball;
    int         m_score;
    int         m_timer;
    logic [1:0] m_btnq;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st    = 0;
        m_ball  = 3;
        m_score = 0;
        m_timer = 0;
        m_btnq  = 2'b00;
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.gs   = (m_st != 1);
        case (m_st)
            0:       s.te = 4'b1110;
            3:       s.te = 4'b1001;
            default: s.te = 4'b1000;
        endcase
        s.ball = 2'(m_ball);
        s.d1   = 4'(m_score / 10);
        s.d0   = 4'(m_score % 10);
        return s;
    endfunction

    task automatic model_step(input logic [1:0] b, input logic h, input logic ms, input logic t);
        bit press;
        bit load;
        press = |(b & ~m_btnq);
        load  = 0;
        case (m_st)
            0: if (press) begin m_ball--; m_st = 1; end
            1: begin
                if (h) m_score = (m_score + 1) % 100;
                if (ms) begin
                    load = 1;
                    if (m_ball == 0) m_st = 3;
                    else begin m_ball--; m_st = 2; end
                end
            end
            2: if (m_timer == 0 && press) m_st = 1;
            default: if (m_timer == 0) begin m_st = 0; m_score = 0; m_ball = 3; end
        endcase
        if (load)                     m_timer = 120;
        else if (t && m_timer > 0)    m_timer = m_timer - 1;
        m_btnq = b;
    endtask

    task automatic compare_now(input string tag, input snap_t e);
        check_value({tag, ".graph_still"}, 32'(graph_still), 32'(e.gs));
        check_value({tag, ".text_en"},     32'(text_en),     32'(e.te));
        check_value({tag, ".ball"},        32'(ball),        32'(e.ball));
        check_value({tag, ".dig1"},        32'(dig1),        32'(e.d1));
        check_value({tag, ".dig0"},        32'(dig0),        32'(e.d0));
    endtask

    // One clock: drive at negedge, predict, then pop and compare after posedge
    task automatic step(input logic [1:0] b, input logic h, input logic ms, input logic t, input string tag);
        snap_t e;
        @(negedge clk);
        btn       = b;
        hit       = h;
        miss      = ms;
        refr_tick = t;
        model_step(b, h, ms, t);
        sb_q.push_back(model_snap());
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_value({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            compare_now(tag, e);
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 1'b1, 1'b0, 1'b0, "hit");
    endtask

    // Tick every cycle for n cycles with a button pressed on odd cycles
    task automatic wait_ticks_pressing(input int n);
        for (int i = 0; i < n; i++) begin
            step((i % 2) ? 2'b10 : 2'b00, 1'b0, 1'b0, 1'b1, "wait");
            if (i == 60) check_value("early_press_ignored.graph_still", 32'(graph_still), 32'd1);
        end
    endtask

    int falls;
    logic prev_gs;

    initial begin
        model_reset();
        // Reset held across a few edges
        #32;
        compare_now("reset", model_snap());
        check_value("reset.text_en_const", 32'(text_en), 32'hE);
        check_value("reset.ball_const", 32'(ball), 32'd3);

        @(negedge clk);
        reset = 1'b1;

        // Hold one button for 10 cycles: exactly one start
        falls   = 0;
        prev_gs = graph_still;
        for (int i = 0; i < 10; i++) begin
            step(2'b01, 1'b0, 1'b0, 1'b0, "start_hold");
            if (prev_gs && !graph_still) falls++;
            prev_gs = graph_still;
        end
        check_value("start.transitions", 32'(falls), 32'd1);
        check_value("start.ball", 32'(ball), 32'd2);
        check_value("start.text_en", 32'(text_en), 32'h8);
        step(2'b00, 1'b0, 1'b0, 1'b0, "release");

        // Score counting and wrap
        for (int i = 0; i < 12; i++) begin
            step(2'b00, 1'b1, 1'b0, 1'b0, "hit12");
            step(2'b00, 1'b0, 1'b0, 1'b0, "idle");
        end
        check_value("score12.dig1", 32'(dig1), 32'd1);
        check_value("score12.dig0", 32'(dig0), 32'd2);
        hits(87);
        check_value("score99.dig1", 32'(dig1), 32'd9);
        check_value("score99.dig0", 32'(dig0), 32'd9);
        hits(1);
        check_value("wrap.dig1", 32'(dig1), 32'd0);
        check_value("wrap.dig0", 32'(dig0), 32'd0);

        // Miss with balls left, then wait/press back into play
        step(2'b00, 1'b0, 1'b1, 1'b0, "miss_nb");
        check_value("newball.ball", 32'(ball), 32'd1);
        check_value("newball.graph_still", 32'(graph_still), 32'd1);
        wait_ticks_pressing(126);
        check_value("newball_back.graph_still", 32'(graph_still), 32'd0);

        // Score 09 then simultaneous hit and miss
        hits(9);
        step(2'b00, 1'b1, 1'b1, 1'b0, "hit_miss");
        check_value("hit_miss.dig1", 32'(dig1), 32'd1);
        check_value("hit_miss.dig0", 32'(dig0), 32'd0);
        check_value("hit_miss.ball", 32'(ball), 32'd0);
        check_value("hit_miss.graph_still", 32'(graph_still), 32'd1);
        step(2'b00, 1'b1, 1'b0, 1'b1, "hit_outside_play");
        wait_ticks_pressing(126);

        // Last ball lost: game over, then timeout back to a new game
        hits(2);
        step(2'b00, 1'b0, 1'b1, 1'b1, "miss_over");
        check_value("over.text_en", 32'(text_en), 32'h9);
        check_value("over.dig0", 32'(dig0), 32'd2);
        for (int i = 0; i < 120; i++) step(2'b00, 1'b0, 1'b0, 1'b1, "over_wait");
        check_value("over_edge.text_en", 32'(text_en), 32'h9);
        step(2'b00, 1'b0, 1'b0, 1'b0, "over_exit");
        check_value("newgame.text_en", 32'(text_en), 32'hE);
        check_value("newgame.dig0", 32'(dig0), 32'd0);
        check_value("newgame.ball", 32'(ball), 32'd3);

        // Play down to OVER again, then reset mid-count
        step(2'b01, 1'b0, 1'b0, 1'b0, "start2");
        step(2'b00, 1'b1, 1'b1, 1'b0, "miss2a");
        wait_ticks_pressing(126);
        step(2'b00, 1'b0, 1'b1, 1'b0, "miss2b");
        wait_ticks_pressing(126);
        step(2'b00, 1'b0, 1'b1, 1'b0, "miss2c");
        for (int i = 0; i < 50; i++) step(2'b00, 1'b0, 1'b0, 1'b1, "over2_wait");
        check_value("over2.text_en", 32'(text_en), 32'h9);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_now("async_reset", model_snap());
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(2'b00, 1'b0, 1'b0, 1'b1, "post_reset_idle");
        step(2'b10, 1'b0, 1'b0, 1'b0, "post_reset_press");
        check_value("post_reset.graph_still", 32'(graph_still), 32'd0);
        check_value("post_reset.ball", 32'(ball), 32'd2);
        check_value("scoreboard.drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pong_game_ctrl
`default_nettype wire
